// File: rtl/m_kitchen_timer_ctrl_pkg.sv
// Shared encodings for the kitchen timer controller: FSM states and counter
// direction constants.
package m_kitchen_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;

  localparam logic MODE_UP   = 1'b0;
  localparam logic MODE_DOWN = 1'b1;

endpackage

// File: rtl/m_button_debounce.sv
// One front-panel button: 2-FF synchronizer, stable-count debouncer and
// rising-edge detect producing a single-cycle press strobe.
module m_button_debounce #(
  parameter int DEBOUNCE_CYC = 500_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // Accept a new level only after it has differed from the accepted one for
  // DEBOUNCE_CYC consecutive cycles; a rising acceptance is the press.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      press_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      if (sync2_q == stable_q) begin
        cnt_q   <= '0;
        press_q <= 1'b0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
        cnt_q    <= '0;
        stable_q <= sync2_q;
        press_q  <= sync2_q;
      end else begin
        cnt_q   <= cnt_q + CW'(1);
        press_q <= 1'b0;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/m_kitchen_timer_ctrl.sv
// Kitchen timer control: button conditioning, 1 s tick, set/run/pause/alarm
// sequencing of the external BCD digit counters, and the buzzer.
module m_kitchen_timer_ctrl
  import m_kitchen_timer_ctrl_pkg::*;
#(
  parameter int TICK_DIV     = 50_000_000,
  parameter int DEBOUNCE_CYC = 500_000,
  parameter int BEEP_DIV     = 25_000,
  parameter int ALARM_SEC    = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        btn_min,
  input  logic        btn_sec,
  input  logic        btn_ss,
  input  logic [15:0] digits,
  output logic        mode,
  output logic        clken,
  output logic        sec_cb,
  output logic        min_cb,
  output logic        running,
  output logic        buzzer
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BEEP_DIV > 1) ? $clog2(BEEP_DIV) : 1;
  localparam int AW = $clog2(ALARM_SEC + 1);

  logic press_min_s, press_sec_s, press_ss_s;

  m_button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_min (
    .clk(clk), .reset_n(reset_n), .btn_i(btn_min), .press_o(press_min_s));
  m_button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_sec (
    .clk(clk), .reset_n(reset_n), .btn_i(btn_sec), .press_o(press_sec_s));
  m_button_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_ss (
    .clk(clk), .reset_n(reset_n), .btn_i(btn_ss), .press_o(press_ss_s));

  state_e        state_q, state_d;
  logic          entry_q;
  logic          mode_q, clken_q, running_q, buzzer_q;
  logic          sec_cb_q, sec_cb_d;
  logic          min_cb_q, min_cb_d;
  logic [TW-1:0] tick_cnt_q;
  logic [BW-1:0] beep_cnt_q;
  logic [AW-1:0] alarm_cnt_q;
  logic          zero_s, tick_s, any_press_s;

  // Next state and pulse requests; entry_q blocks pulses in a state's first cycle.
  always_comb begin
    zero_s      = (digits == 16'h0000);
    tick_s      = ((state_q == ST_RUN) || (state_q == ST_ALARM)) &&
                  (tick_cnt_q == TW'(TICK_DIV - 1));
    any_press_s = press_min_s | press_sec_s | press_ss_s;
    state_d     = state_q;
    sec_cb_d    = 1'b0;
    min_cb_d    = 1'b0;
    case (state_q)
      ST_SET: begin
        if (press_ss_s) begin
          state_d = zero_s ? ST_SET : ST_RUN;
        end else begin
          sec_cb_d = press_sec_s & ~entry_q;
          min_cb_d = press_min_s & ~entry_q;
        end
      end
      ST_RUN: begin
        if (press_ss_s) begin
          state_d = ST_PAUSE;
        end else if (tick_s && zero_s) begin
          state_d = ST_ALARM;
        end else begin
          sec_cb_d = tick_s & ~entry_q;
        end
      end
      ST_PAUSE: begin
        if (press_ss_s) begin
          state_d = ST_RUN;
        end else if (press_min_s || press_sec_s) begin
          state_d = ST_SET;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      ST_ALARM: begin
        if (any_press_s || (tick_s && (alarm_cnt_q == AW'(ALARM_SEC - 1)))) begin
          state_d = ST_SET;
        end else begin
          state_d = ST_ALARM;
        end
      end
      default: state_d = ST_SET;
    endcase
  end

  // State register, registered outputs, tick/beep/alarm counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_SET;
      entry_q     <= 1'b0;
      mode_q      <= MODE_UP;
      clken_q     <= 1'b0;
      running_q   <= 1'b0;
      buzzer_q    <= 1'b0;
      sec_cb_q    <= 1'b0;
      min_cb_q    <= 1'b0;
      tick_cnt_q  <= '0;
      beep_cnt_q  <= '0;
      alarm_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      entry_q   <= (state_d != state_q);
      mode_q    <= ((state_d == ST_RUN) || (state_d == ST_PAUSE)) ? MODE_DOWN : MODE_UP;
      clken_q   <= (state_d == ST_RUN);
      running_q <= (state_d == ST_RUN);
      sec_cb_q  <= sec_cb_d;
      min_cb_q  <= min_cb_d;

      if ((state_d == ST_RUN) && (state_q != ST_RUN)) begin
        tick_cnt_q <= '0;
      end else if ((state_q == ST_RUN) || (state_q == ST_ALARM)) begin
        tick_cnt_q <= tick_s ? '0 : tick_cnt_q + TW'(1);
      end else begin
        tick_cnt_q <= tick_cnt_q;
      end

      // Beep divider and tick count restart on every ALARM entry and clear on exit.
      if ((state_q == ST_ALARM) && (state_d == ST_ALARM)) begin
        if (beep_cnt_q == BW'(BEEP_DIV - 1)) begin
          beep_cnt_q <= '0;
          buzzer_q   <= ~buzzer_q;
        end else begin
          beep_cnt_q <= beep_cnt_q + BW'(1);
          buzzer_q   <= buzzer_q;
        end
        alarm_cnt_q <= tick_s ? alarm_cnt_q + AW'(1) : alarm_cnt_q;
      end else begin
        beep_cnt_q  <= '0;
        buzzer_q    <= 1'b0;
        alarm_cnt_q <= '0;
      end
    end
  end

  assign mode    = mode_q;
  assign clken   = clken_q;
  assign running = running_q;
  assign buzzer  = buzzer_q;
  assign sec_cb  = sec_cb_q;
  assign min_cb  = min_cb_q;

endmodule

// File: tb/tb_m_kitchen_timer_ctrl.sv
// Directed bench for m_kitchen_timer_ctrl with a behavioural model of the
// cascaded MM:SS BCD counters driven by mode/clken/sec_cb/min_cb.
module tb_m_kitchen_timer_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        btn_min, btn_sec, btn_ss;
  logic [15:0] digits = 16'h0000;
  logic        mode, clken, sec_cb, min_cb, running, buzzer;

  logic        load_req = 1'b0;
  logic [15:0] load_val = 16'h0000;
  int          cyc = 0;
  int          sec_n = 0;
  int          min_n = 0;
  int          wide_n = 0;
  logic        prev_sec_cb = 1'b0;
  logic        prev_min_cb = 1'b0;

  int errors = 0;
  int checks = 0;

  m_kitchen_timer_ctrl #(
    .TICK_DIV(10), .DEBOUNCE_CYC(4), .BEEP_DIV(3), .ALARM_SEC(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .btn_min(btn_min), .btn_sec(btn_sec),
    .btn_ss(btn_ss), .digits(digits), .mode(mode), .clken(clken),
    .sec_cb(sec_cb), .min_cb(min_cb), .running(running), .buzzer(buzzer)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] inc_sec(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (r[3:0] < 4'd9) r[3:0] = r[3:0] + 4'd1;
    else begin
      r[3:0] = 4'd0;
      r[7:4] = (r[7:4] < 4'd5) ? r[7:4] + 4'd1 : 4'd0;
    end
    return r;
  endfunction

  function automatic logic [15:0] inc_min(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (r[11:8] < 4'd9) r[11:8] = r[11:8] + 4'd1;
    else begin
      r[11:8]  = 4'd0;
      r[15:12] = (r[15:12] < 4'd9) ? r[15:12] + 4'd1 : 4'd0;
    end
    return r;
  endfunction

  function automatic logic [15:0] dec_time(input logic [15:0] d);
    logic [15:0] r;
    r = d;
    if (r[3:0] != 4'd0) r[3:0] = r[3:0] - 4'd1;
    else begin
      r[3:0] = 4'd9;
      if (r[7:4] != 4'd0) r[7:4] = r[7:4] - 4'd1;
      else begin
        r[7:4] = 4'd5;
        if (r[11:8] != 4'd0) r[11:8] = r[11:8] - 4'd1;
        else begin
          r[11:8]  = 4'd9;
          r[15:12] = r[15:12] - 4'd1;
        end
      end
    end
    return r;
  endfunction

  // Digit counter model plus pulse bookkeeping.
  always @(posedge clk) begin
    logic [15:0] nd;
    cyc <= cyc + 1;
    if (load_req) begin
      digits <= load_val;
    end else begin
      nd = digits;
      if (sec_cb) nd = mode ? (clken ? dec_time(nd) : nd) : inc_sec(nd);
      if (min_cb && !mode) nd = inc_min(nd);
      digits <= nd;
    end
    if (sec_cb) sec_n <= sec_n + 1;
    if (min_cb) min_n <= min_n + 1;
    if ((sec_cb && prev_sec_cb) || (min_cb && prev_min_cb)) wide_n <= wide_n + 1;
    prev_sec_cb <= sec_cb;
    prev_min_cb <= min_cb;
  end

  task automatic set_btn(input int which, input logic v);
    case (which)
      0:       btn_sec = v;
      1:       btn_min = v;
      default: btn_ss  = v;
    endcase
  endtask

  task automatic press_btn(input int which);
    set_btn(which, 1'b1);
    repeat (8) @(negedge clk);
    set_btn(which, 1'b0);
    repeat (8) @(negedge clk);
  endtask

  task automatic load_digits(input logic [15:0] v);
    @(negedge clk);
    load_val = v;
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
  endtask

  task automatic wait_sec_cb(input int budget, output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sec_cb) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic wait_running(input int budget, output bit ok, output int t);
    ok = 1'b0;
    t  = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (running) begin
        ok = 1'b1;
        t  = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      btn_min = i[0];
      btn_sec = ~i[0];
      btn_ss  = i[1];
    end
    #1;
    checks++;
    if ({mode, clken, sec_cb, min_cb, running, buzzer} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 000000",
               {mode, clken, sec_cb, min_cb, running, buzzer});
    end
    btn_min = 1'b0; btn_sec = 1'b0; btn_ss = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if ({mode, clken, running, buzzer} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release_set: got mode/clken/run/buz=%b want 0000",
               {mode, clken, running, buzzer});
    end
  endtask

  task automatic test_set_time;
    int s, m, w;
    load_digits(16'h0000);
    s = sec_n; m = min_n; w = wide_n;
    for (int i = 0; i < 3; i++) press_btn(0);
    press_btn(1);
    checks++;
    if (sec_n - s !== 3) begin
      errors++;
      $display("FAIL set_sec_pulses: got %0d want 3", sec_n - s);
    end
    checks++;
    if (min_n - m !== 1) begin
      errors++;
      $display("FAIL set_min_pulses: got %0d want 1", min_n - m);
    end
    checks++;
    if (wide_n - w !== 0) begin
      errors++;
      $display("FAIL set_pulse_width: got %0d wide pulses want 0", wide_n - w);
    end
    checks++;
    if (digits !== 16'h0103) begin
      errors++;
      $display("FAIL set_digits: got %h want 0103", digits);
    end
  endtask

  task automatic test_run_alarm;
    bit ok;
    int t0, t1, t2, t3, ta, s0;
    logic [23:0] buz, exp_buz;
    load_digits(16'h0003);
    s0 = sec_n;
    btn_ss = 1'b1;
    wait_running(20, ok, t0);
    btn_ss = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL run_enter: got running=0 want 1 within 20 cycles");
    end
    wait_sec_cb(20, ok, t1);
    checks++;
    if (!ok || !((t1 - t0 == 10) || (t1 - t0 == 11)) || mode !== 1'b1) begin
      errors++;
      $display("FAIL run_first_pulse: got ok=%0d delay=%0d mode=%b want delay 10..11 mode 1",
               ok, t1 - t0, mode);
    end
    wait_sec_cb(15, ok, t2);
    wait_sec_cb(15, ok, t3);
    checks++;
    if ((t2 - t1 !== 10) || (t3 - t2 !== 10)) begin
      errors++;
      $display("FAIL run_pulse_spacing: got %0d,%0d want 10,10", t2 - t1, t3 - t2);
    end
    @(negedge clk);
    checks++;
    if (digits !== 16'h0000) begin
      errors++;
      $display("FAIL run_count_zero: got %h want 0000", digits);
    end
    ok = 1'b0;
    ta = 0;
    for (int i = 0; i < 15; i++) begin
      if (!running) begin
        ok = 1'b1;
        ta = cyc;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ok || (ta - t3 !== 10) || (sec_n - s0 !== 3) || mode !== 1'b0) begin
      errors++;
      $display("FAIL alarm_entry: got ok=%0d delay=%0d pulses=%0d mode=%b want delay 10 pulses 3 mode 0",
               ok, ta - t3, sec_n - s0, mode);
    end
    for (int k = 0; k < 24; k++) begin
      buz[k]     = buzzer;
      exp_buz[k] = (k < 20) ? (((k / 3) % 2) == 1) : 1'b0;
      @(negedge clk);
    end
    checks++;
    if (buz !== exp_buz) begin
      errors++;
      $display("FAIL alarm_buzzer: got %b want %b", buz, exp_buz);
    end
    s0 = sec_n;
    press_btn(0);
    checks++;
    if ((sec_n - s0 !== 1) || (digits !== 16'h0001)) begin
      errors++;
      $display("FAIL alarm_back_to_set: got pulses=%0d digits=%h want 1 0001", sec_n - s0, digits);
    end
  endtask

  task automatic test_start_zero;
    int s, m;
    bit seen;
    load_digits(16'h0000);
    s = sec_n; m = min_n; seen = 1'b0;
    btn_ss = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (i == 10) btn_ss = 1'b0;
      if (running || clken) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL zero_no_run: got running=1 want 0");
    end
    checks++;
    if ((sec_n != s) || (min_n != m)) begin
      errors++;
      $display("FAIL zero_no_pulse: got %0d/%0d pulses want 0/0", sec_n - s, min_n - m);
    end
  endtask

  task automatic test_pause_edit;
    bit ok;
    int t, tr, s;
    load_digits(16'h0100);
    btn_ss = 1'b1;
    wait_running(20, ok, t);
    btn_ss = 1'b0;
    wait_sec_cb(20, ok, t);
    wait_sec_cb(15, ok, t);
    btn_ss = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!clken) begin
        ok = 1'b1;
        break;
      end
    end
    btn_ss = 1'b0;
    checks++;
    if (!ok || running !== 1'b0 || mode !== 1'b1) begin
      errors++;
      $display("FAIL pause_enter: got ok=%0d running=%b mode=%b want 1 0 1", ok, running, mode);
    end
    s = sec_n;
    repeat (50) @(negedge clk);
    checks++;
    if ((sec_n != s) || clken !== 1'b0 || digits !== 16'h0058) begin
      errors++;
      $display("FAIL pause_hold: got pulses=%0d clken=%b digits=%h want 0 0 0058",
               sec_n - s, clken, digits);
    end
    press_btn(0);
    checks++;
    if (mode !== 1'b0 || sec_n != s) begin
      errors++;
      $display("FAIL pause_to_set: got mode=%b pulses=%0d want 0 0", mode, sec_n - s);
    end
    press_btn(0);
    checks++;
    if ((sec_n - s !== 1) || digits !== 16'h0059) begin
      errors++;
      $display("FAIL edit_sec: got pulses=%0d digits=%h want 1 0059", sec_n - s, digits);
    end
    btn_ss = 1'b1;
    wait_running(20, ok, tr);
    btn_ss = 1'b0;
    wait_sec_cb(15, ok, t);
    @(negedge clk);
    checks++;
    if (!ok || !((t - tr == 10) || (t - tr == 11)) || digits !== 16'h0058) begin
      errors++;
      $display("FAIL resume_run: got ok=%0d delay=%0d digits=%h want delay 10..11 0058",
               ok, t - tr, digits);
    end
    btn_ss = 1'b1;
    repeat (10) @(negedge clk);
    btn_ss = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_glitch_abort;
    bit ok;
    bit buz_seen;
    int s, t;
    load_digits(16'h0000);
    s = sec_n;
    btn_sec = 1'b1;
    repeat (3) @(negedge clk);
    btn_sec = 1'b0;
    repeat (12) @(negedge clk);
    checks++;
    if (sec_n != s) begin
      errors++;
      $display("FAIL glitch_rejected: got %0d pulses want 0", sec_n - s);
    end
    load_digits(16'h0001);
    btn_ss = 1'b1;
    wait_running(20, ok, t);
    btn_ss = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!running) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok || mode !== 1'b0 || digits !== 16'h0000) begin
      errors++;
      $display("FAIL abort_alarm_entry: got ok=%0d mode=%b digits=%h want 1 0 0000", ok, mode, digits);
    end
    btn_ss = 1'b1;
    repeat (8) @(negedge clk);
    btn_ss = 1'b0;
    buz_seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (buzzer) buz_seen = 1'b1;
    end
    checks++;
    if (buz_seen) begin
      errors++;
      $display("FAIL abort_buzzer_off: got buzzer=1 want 0 after ss press");
    end
    s = sec_n;
    press_btn(0);
    checks++;
    if (sec_n - s !== 1) begin
      errors++;
      $display("FAIL abort_in_set: got %0d pulses want 1", sec_n - s);
    end
    load_digits(16'h0100);
    btn_ss = 1'b1;
    wait_running(20, ok, t);
    btn_ss = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if ({mode, clken, sec_cb, min_cb, running, buzzer} !== 6'b0) begin
      errors++;
      $display("FAIL reset_mid_run: got %b want 000000",
               {mode, clken, sec_cb, min_cb, running, buzzer});
    end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    checks++;
    if (running !== 1'b0 || mode !== 1'b0) begin
      errors++;
      $display("FAIL reset_resume_set: got running=%b mode=%b want 0 0", running, mode);
    end
  endtask

  initial begin
    btn_min = 1'b0;
    btn_sec = 1'b0;
    btn_ss  = 1'b0;
    reset_n = 1'b0;
    test_reset();
    test_set_time();
    test_run_alarm();
    test_start_zero();
    test_pause_edit();
    test_glitch_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/m_kitchen_timer_ctrl.md
# m_kitchen_timer_ctrl

Control block for the kitchen timer. It drives the cascaded BCD up/down digit counters (MM:SS) through their `mode`, `clken` and carry/borrow-in inputs, and reads the digit values back. It debounces the three front-panel buttons and generates the 1 Hz count-down tick. It sequences set, run, pause and alarm phases and drives the buzzer.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: clk cycles per 1 s tick.
- `DEBOUNCE_CYC`, 500_000: cycles a synchronized button level must stay stable before it is accepted.
- `BEEP_DIV`, 25_000: half-period of the buzzer square wave, in clk cycles.
- `ALARM_SEC`, 10: seconds of buzzing before automatic return to SET.

Ports:
- `clk` in 1: system clock; only clock in the block.
- `reset_n` in 1: asynchronous, active-low reset.
- `btn_min` in 1: raw, asynchronous, active-high minute-increment button.
- `btn_sec` in 1: raw, asynchronous, active-high second-increment button.
- `btn_ss` in 1: raw, asynchronous, active-high start/stop button.
- `digits` in 16: counter values {min10, min1, sec10, sec1}, 4-bit BCD each.
- `mode` out 1: 0 = count up (set), 1 = count down (run); drives all digit counters.
- `clken` out 1: down-count enable to all digit counters.
- `sec_cb` out 1: one-cycle carry/borrow-in pulse to the sec1 counter.
- `min_cb` out 1: one-cycle carry-in pulse to the min1 counter; used in SET only.
- `running` out 1: high in RUN.
- `buzzer` out 1: square wave in ALARM, otherwise 0.

## Operation
- Button path, per button: 2-FF synchronizer, then a stable-count debouncer (`DEBOUNCE_CYC`), then rising-edge detect. The result is a one-cycle `press` strobe.
- Tick generator: counter 0..`TICK_DIV`-1. It runs only in RUN and ALARM and is cleared to 0 on entry to RUN. The `tick` strobe fires when the counter reaches `TICK_DIV`-1.
- `zero` = (`digits` == 16'h0000).

FSM states and transitions:
- SET:
  - `mode`=0, `clken`=0.
  - press_sec → `sec_cb` pulse.
  - press_min → `min_cb` pulse.
  - press_ss with !zero → RUN.
  - press_ss with zero → stay in SET.
  - Simultaneous presses: ss wins over the increments; min and sec together produce both pulses.
- RUN:
  - `mode`=1, `clken`=1, `running`=1.
  - tick with !zero → `sec_cb` pulse.
  - tick with zero → ALARM, with no pulse.
  - press_ss → PAUSE; a tick in the same cycle is dropped.
  - press_min and press_sec are ignored.
- PAUSE:
  - `mode`=1, `clken`=0, no pulses.
  - press_ss → RUN.
  - press_min or press_sec → SET; this is how the user edits the remaining time.
- ALARM:
  - `mode`=0, `clken`=0.
  - `buzzer` toggles every `BEEP_DIV` cycles, starting at 0.
  - A second counter counts ticks. After `ALARM_SEC` ticks, or on any press, the FSM goes to SET.
  - `buzzer` is forced to 0 on exit.
- No clear function: the digits read 0 after the alarm, and the user sets a new time from zero.

## Timing
- Reset values: state SET, all outputs 0, all counters 0, synchronizers 0.
- Press latency: button edge → `press` strobe in 2 + `DEBOUNCE_CYC` + 1 cycles, ±1.
- State outputs (`mode`, `clken`, `running`) are registered and change on the edge that enters a state.
- `sec_cb` and `min_cb` are registered. They are suppressed in the first cycle of any state, so `mode` is always stable for at least one cycle before any pulse.
- Count rate in RUN: first `sec_cb` pulse `TICK_DIV` cycles after RUN entry (+1 for the suppressed cycle), then one every `TICK_DIV` cycles.
- Each `cb` pulse is exactly 1 cycle, so the counters advance by exactly 1 per pulse.
- `zero` is sampled from `digits` in the tick cycle. The counter update from the previous pulse has settled by then, since pulses are at least `TICK_DIV` cycles apart.
- `reset_n` asserted mid-RUN or mid-ALARM: all outputs go to 0 asynchronously and the FSM resumes in SET. The digit counters are not reset by this block.

## Structure
- Shared package or header: state encodings (SET=0, RUN=1, PAUSE=2, ALARM=3) and the `mode` constants (MODE_UP=0, MODE_DOWN=1).
- One sub-module, `m_button_debounce` (sync + debounce + edge detect, parameter `DEBOUNCE_CYC`), instantiated three times.
- Tick generator, beep divider and FSM stay in the top module.

## Test plan
Bench settings: `TICK_DIV`=10, `DEBOUNCE_CYC`=4, `BEEP_DIV`=3, `ALARM_SEC`=2. The bench models the digit counters.

- Reset: hold `reset_n`=0 with buttons toggling → all outputs 0. Release → SET, `mode`=0.
- Set time: 3 sec presses and 1 min press → exactly 3 `sec_cb` and 1 `min_cb` single-cycle pulses; digits = 01:03.
- Run to alarm: from 00:03 press ss → `mode`=1 one cycle before the first pulse; pulses 10 cycles apart; after 00:00, the next tick enters ALARM; `buzzer` period is 6 cycles; return to SET after 2 ticks with `buzzer`=0.
- Start at zero: digits 00:00, press ss → stays in SET, no pulses, `running`=0.
- Pause and edit: run 01:00, press ss after 2 pulses → PAUSE, `clken`=0, no pulses for 50 cycles. Press sec → SET, `sec_cb` pulse; press ss → RUN resumes.
- Glitch and abort: a button bounce shorter than 4 cycles → no press. Press ss during ALARM → SET immediately. `reset_n` pulse mid-RUN → outputs 0 within the same cycle.
